// File: rtl/wb_pio_pwm_ctrl_if.sv
// Wishbone slave bus bundle for the PIO/PWM controller.
// Pure wiring; the slave owns ACK timing and read-data registration.
interface wb_pio_pwm_ctrl_if #(
    parameter int ADDRWIDTH = 7
);
    logic [ADDRWIDTH-1:0] WBs_ADR;
    logic                 WBs_CYC;
    logic                 WBs_STB;
    logic                 WBs_WE;
    logic [3:0]           WBs_BYTE_STB;
    logic [31:0]          WBs_WR_DAT;
    logic [31:0]          WBs_RD_DAT;
    logic                 WBs_ACK;

    modport master (
        output WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_BYTE_STB, WBs_WR_DAT,
        input  WBs_RD_DAT, WBs_ACK
    );

    modport slave (
        input  WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_BYTE_STB, WBs_WR_DAT,
        output WBs_RD_DAT, WBs_ACK
    );
endinterface

// File: rtl/wb_pio_pwm_ctrl.sv
// Wishbone PIO controller: per-channel static / PWM / one-shot outputs, W1C interrupt status.
// Latency: ACK + read data 1 cycle after CYC&STB, pio_o 1 cycle after write ACK; no backpressure, zero wait states.
module wb_pio_pwm_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 16,
    parameter int ADDRWIDTH = 7
) (
    input  logic              WB_CLK,
    input  logic              WB_RST,
    wb_pio_pwm_ctrl_if.slave  wb,
    output logic [NUM_CH-1:0] pio_o,
    output logic              Interrupt_o
);
    typedef enum logic [1:0] {OS_IDLE, OS_RUN, OS_DONE} os_state_e;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam logic [1:0]  MODE_PWM = 2'b01;
    localparam logic [1:0]  MODE_OS  = 2'b10;
    localparam logic [31:0] ID_VAL   = {16'h5010, 8'd0, 8'(NUM_CH)};
    localparam logic [31:0] UNMAPPED = 32'hDEAD_0000;

    logic                ack_q, ack_d;
    logic [31:0]         rd_dat_q, rd_dat_d;
    logic [2*NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0]   out_q, out_d;
    logic [NUM_CH-1:0]   int_stat_q, int_stat_d;
    logic [NUM_CH-1:0]   int_en_q, int_en_d;
    logic [NUM_CH-1:0]   pio_q, pio_d;
    cnt_t                period_q [NUM_CH];
    cnt_t                period_d [NUM_CH];
    cnt_t                duty_q [NUM_CH];
    cnt_t                duty_d [NUM_CH];
    cnt_t                per_act_q [NUM_CH];
    cnt_t                per_act_d [NUM_CH];
    cnt_t                duty_act_q [NUM_CH];
    cnt_t                duty_act_d [NUM_CH];
    cnt_t                pwm_cnt_q [NUM_CH];
    cnt_t                pwm_cnt_d [NUM_CH];
    cnt_t                os_cnt_q [NUM_CH];
    cnt_t                os_cnt_d [NUM_CH];
    os_state_e           os_state_q [NUM_CH];
    os_state_e           os_state_d [NUM_CH];

    logic [ADDRWIDTH-1:0] adr;
    logic [31:0]          adr32, wmask, wbits, rdata, tmp;
    logic                 access, wr_en;
    logic [NUM_CH-1:0]    trig, w1c, int_set;
    logic [1:0]           mode_ch;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] mask,
                                          input logic [31:0] dat);
        return (old & ~mask) | (dat & mask);
    endfunction

    always_comb begin
        adr    = wb.WBs_ADR;
        adr32  = 32'(adr);
        access = wb.WBs_CYC & wb.WBs_STB & ~ack_q;
        wr_en  = access & wb.WBs_WE;
        wmask  = '0;
        for (int b = 0; b < 4; b++) begin
            wmask[8*b +: 8] = {8{wb.WBs_BYTE_STB[b]}};
        end
        wbits      = wb.WBs_WR_DAT & wmask;
        ack_d      = access;
        tmp        = '0;
        mode_ch    = '0;
        trig       = '0;
        w1c        = '0;
        int_set    = '0;
        pio_d      = '0;
        mode_d     = mode_q;
        out_d      = out_q;
        int_en_d   = int_en_q;
        period_d   = period_q;
        duty_d     = duty_q;
        per_act_d  = per_act_q;
        duty_act_d = duty_act_q;
        pwm_cnt_d  = pwm_cnt_q;
        os_cnt_d   = os_cnt_q;
        os_state_d = os_state_q;

        rdata = UNMAPPED;
        case (adr32)
            32'd0:   rdata = ID_VAL;
            32'd1:   rdata = 32'(mode_q);
            32'd2:   rdata = 32'(out_q);
            32'd3:   rdata = 32'(int_stat_q);
            32'd4:   rdata = 32'(int_en_q);
            32'd5:   rdata = '0;
            default: ;
        endcase
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (adr32 == 32'(8 + 2*ch)) rdata = 32'(period_q[ch]);
            if (adr32 == 32'(9 + 2*ch)) rdata = 32'(duty_q[ch]);
        end
        rd_dat_d = (access && !wb.WBs_WE) ? rdata : '0;

        if (wr_en) begin
            case (adr32)
                32'd1: begin
                    tmp    = merge(32'(mode_q), wmask, wb.WBs_WR_DAT);
                    mode_d = tmp[2*NUM_CH-1:0];
                end
                32'd2: begin
                    tmp   = merge(32'(out_q), wmask, wb.WBs_WR_DAT);
                    out_d = tmp[NUM_CH-1:0];
                end
                32'd3: w1c = wbits[NUM_CH-1:0];
                32'd4: begin
                    tmp      = merge(32'(int_en_q), wmask, wb.WBs_WR_DAT);
                    int_en_d = tmp[NUM_CH-1:0];
                end
                32'd5: trig = wbits[NUM_CH-1:0];
                default: ;
            endcase
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (adr32 == 32'(8 + 2*ch)) begin
                    tmp          = merge(32'(period_q[ch]), wmask, wb.WBs_WR_DAT);
                    period_d[ch] = tmp[CNT_WIDTH-1:0];
                end
                if (adr32 == 32'(9 + 2*ch)) begin
                    tmp        = merge(32'(duty_q[ch]), wmask, wb.WBs_WR_DAT);
                    duty_d[ch] = tmp[CNT_WIDTH-1:0];
                end
            end
        end

        for (int ch = 0; ch < NUM_CH; ch++) begin
            mode_ch = mode_q[2*ch +: 2];

            // Shadows track the programmed values until PWM runs, then only reload at wrap.
            if (mode_ch == MODE_PWM) begin
                if (pwm_cnt_q[ch] >= per_act_q[ch]) begin
                    pwm_cnt_d[ch]  = '0;
                    per_act_d[ch]  = period_q[ch];
                    duty_act_d[ch] = duty_q[ch];
                end else begin
                    pwm_cnt_d[ch] = pwm_cnt_q[ch] + CNT_WIDTH'(1);
                end
            end else begin
                pwm_cnt_d[ch]  = '0;
                per_act_d[ch]  = period_q[ch];
                duty_act_d[ch] = duty_q[ch];
            end

            case (os_state_q[ch])
                OS_IDLE: begin
                    if (mode_ch == MODE_OS && trig[ch]) begin
                        if (duty_q[ch] == '0) begin
                            os_state_d[ch] = OS_DONE;
                        end else begin
                            os_state_d[ch] = OS_RUN;
                            os_cnt_d[ch]   = duty_q[ch];
                        end
                    end
                end
                OS_RUN: begin
                    if (mode_ch != MODE_OS) begin
                        os_state_d[ch] = OS_IDLE;
                    end else if (os_cnt_q[ch] == CNT_WIDTH'(1)) begin
                        os_state_d[ch] = OS_DONE;
                    end else begin
                        os_cnt_d[ch] = os_cnt_q[ch] - CNT_WIDTH'(1);
                    end
                end
                OS_DONE: begin
                    int_set[ch]    = 1'b1;
                    os_state_d[ch] = OS_IDLE;
                end
                default: os_state_d[ch] = OS_IDLE;
            endcase

            case (mode_ch)
                MODE_PWM: pio_d[ch] = pwm_cnt_q[ch] < duty_act_q[ch];
                MODE_OS:  pio_d[ch] = os_state_q[ch] == OS_RUN;
                default:  pio_d[ch] = out_q[ch];
            endcase
        end

        // A completion landing on the same edge as a W1C keeps the bit set.
        int_stat_d = (int_stat_q & ~w1c) | int_set;
    end

    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            ack_q      <= 1'b0;
            rd_dat_q   <= '0;
            mode_q     <= '0;
            out_q      <= '0;
            int_stat_q <= '0;
            int_en_q   <= '0;
            pio_q      <= '0;
            period_q   <= '{default: '0};
            duty_q     <= '{default: '0};
            per_act_q  <= '{default: '0};
            duty_act_q <= '{default: '0};
            pwm_cnt_q  <= '{default: '0};
            os_cnt_q   <= '{default: '0};
            os_state_q <= '{default: OS_IDLE};
        end else begin
            ack_q      <= ack_d;
            rd_dat_q   <= rd_dat_d;
            mode_q     <= mode_d;
            out_q      <= out_d;
            int_stat_q <= int_stat_d;
            int_en_q   <= int_en_d;
            pio_q      <= pio_d;
            period_q   <= period_d;
            duty_q     <= duty_d;
            per_act_q  <= per_act_d;
            duty_act_q <= duty_act_d;
            pwm_cnt_q  <= pwm_cnt_d;
            os_cnt_q   <= os_cnt_d;
            os_state_q <= os_state_d;
        end
    end

    assign wb.WBs_ACK    = ack_q;
    assign wb.WBs_RD_DAT = rd_dat_q;
    assign pio_o         = pio_q;
    assign Interrupt_o   = |(int_stat_q & int_en_q);
endmodule
